// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds op encodings, FSM states and the counter width helper.
package muldiv_pkg;

    localparam int OP_W = 2;

    // bit1 selects divide, bit0 selects signed
    typedef enum logic [OP_W-1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    // Counter must hold values 0..w
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the control unit and muldiv_seq.
// master: start/op/a/b/wr_hi/wr_lo/wdata out; busy/done/hi/lo in.
interface muldiv_seq_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq_cla_adder.sv
// WIDTH-bit adder built from rippled 4-bit carry-lookahead cells.
// Ports: a, b, cin -> sum, cout.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NCELL = WIDTH / 4;

    logic [NCELL:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NCELL; i++) begin : g_cell
        cla4 u_cell (
            .a   (a[4*i +: 4]),
            .b   (b[4*i +: 4]),
            .cin (c[i]),
            .sum (sum[4*i +: 4]),
            .cout(c[i+1])
        );
    end

    assign cout = c[NCELL];
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer writing the HI/LO pair.
// Ports: clk, rst_n (sync, active-low), bus (muldiv_seq_if slave).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int CW = cnt_w(WIDTH);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] md;
    logic             is_div;
    logic             q_neg;
    logic             r_neg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH-1:0] sh_rem;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             accept;

    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_neg;
    logic [WIDTH-1:0]   rem_neg;

    assign a_neg = bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = bus.op[0] & bus.b[WIDTH-1];
    assign a_mag = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

    // Divide: rem shifted left with the quotient MSB pulled in;
    // subtract as rem + ~divisor + 1 on the shared adder.
    assign sh_rem  = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    assign add_a   = is_div ? sh_rem : acc_hi;
    assign add_b   = is_div ? ~md : (acc_lo[0] ? md : '0);
    assign add_cin = is_div;

    // A set bit shifted out of rem means rem >= divisor regardless
    assign accept = add_cout | acc_hi[WIDTH-1];

    cla_adder #(.WIDTH(WIDTH)) u_add (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    assign prod_neg = ~{acc_hi, acc_lo} + (2*WIDTH)'(1);
    assign quo_neg  = ~acc_lo + WIDTH'(1);
    assign rem_neg  = ~acc_hi + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            md       <= '0;
            is_div   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        // acc_lo holds multiplier or dividend,
                        // md holds multiplicand or divisor
                        acc_hi   <= '0;
                        acc_lo   <= bus.op[1] ? a_mag : b_mag;
                        md       <= bus.op[1] ? b_mag : a_mag;
                        is_div   <= bus.op[1];
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end else begin
                        if (bus.wr_hi) bus.hi <= bus.wdata;
                        if (bus.wr_lo) bus.lo <= bus.wdata;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= accept ? add_sum : sh_rem;
                        acc_lo <= {acc_lo[WIDTH-2:0], accept};
                    end else begin
                        {acc_hi, acc_lo} <= {add_cout, add_sum,
                                             acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        bus.lo <= q_neg ? quo_neg : acc_lo;
                        bus.hi <= r_neg ? rem_neg : acc_hi;
                    end else begin
                        {bus.hi, bus.lo} <= q_neg ? prod_neg
                                                  : {acc_hi, acc_lo};
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer for the single-cycle CPU. It executes MULT, MULTU, DIV and DIVU on 32-bit operands and writes the HI/LO register pair. Each operation is one shift-add or restoring-subtract step per clock on a single shared carry-lookahead adder. It sits beside the main ALU; the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of 4. Iteration count equals `WIDTH`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: bit1 = divide (0 = multiply); bit0 = signed (1 = MULT/DIV).
- `a` in WIDTH: multiplicand or dividend; captured with `start`.
- `b` in WIDTH: multiplier or divisor; captured with `start`.
- `wr_hi` in 1: MTHI strobe.
- `wr_lo` in 1: MTLO strobe.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when `hi`/`lo` hold a new result.
- `hi` out WIDTH: HI register (product high half or remainder).
- `lo` out WIDTH: LO register (product low half or quotient).

## Operation
- **Reset** (`rst_n` = 0 at an edge), including mid-operation:
  - state returns to IDLE
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0
  - counter and operand registers are cleared
- **Setup, shared by all ops.**
  - Signed ops convert operands to magnitudes.
  - Result signs are latched in setup:
    - product/quotient negative = `a[W-1]` XOR `b[W-1]`
    - remainder negative = `a[W-1]`
- **IDLE.**
  - On `start`: capture magnitudes and signs, clear the counter, go to CALC.
  - Otherwise apply `wr_hi`/`wr_lo`; both strobes may be set in the same cycle.
  - If `start` and a write strobe arrive in the same cycle, `start` wins and the write is dropped.
- **CALC**: one iteration per cycle, `WIDTH` cycles in total.
  - Multiply step:
    - If the multiplier LSB is 1, {carry, acc_hi} = acc_hi + multiplicand; otherwise the sum is acc_hi.
    - Then shift {carry, acc_hi, acc_lo} right by 1.
  - Divide step:
    - Shift {rem, quo} left by 1.
    - Compute trial = rem − divisor, using `b` inverted with carry-in 1.
    - Accept the trial if carry-out is 1 or the bit shifted out of rem was 1. On accept, rem = trial and quo LSB = 1.
  - After the last iteration, go to FIX.
- **FIX**: apply sign correction by two's-complement negation where the latched sign requires it.
  - Multiply: negate the full 2W-bit product.
  - Divide: negate the quotient and the remainder independently.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- **Divide by zero** completes with normal latency and gives:
  - unsigned: `lo` = all ones, `hi` = dividend
  - signed: the unsigned result, then sign correction
- **Signed overflow** (−2^(W−1) / −1) gives `lo` = 0x80000000, `hi` = 0. No trap is raised.
- **Writes while busy**: `start`, `wr_hi` and `wr_lo` are all ignored and have no queued effect.

## Timing
- `start` sampled at edge k:
  - `busy` = 1 from edge k to edge k+WIDTH+1
  - CALC occupies edges k+1 … k+WIDTH
  - FIX is edge k+WIDTH+1
- At edge k+WIDTH+1, `hi`/`lo` update and `done` = 1 for exactly one cycle, while `busy` = 0 in that same cycle.
- With WIDTH = 32: `done` rises 33 edges after `start` is captured.
- Back-to-back: `start` may be high in the `done` cycle and is accepted. Throughput is one op per WIDTH+2 cycles.
- MTHI/MTLO writes are visible on `hi`/`lo` the cycle after the strobe edge.
- `hi`/`lo` hold their previous value for the whole operation; no partial results are exposed.

## Structure
- `muldiv_pkg` holds:
  - op encodings: MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11
  - state enum: IDLE, CALC, FIX
  - counter width function: clog2(WIDTH+1)
- Sub-module `cla_adder`, parameterised on `WIDTH`:
  - ripples WIDTH/4 existing 4-bit lookahead cells
  - ports: a, b, cin → sum, cout
  - one instance, shared by multiply and divide iterations
- FIX-state negation uses its own incrementer, not the shared adder.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `done` exactly 33 edges after `start`; `busy` high for 33 cycles.
- MULT −3 × 7 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB. DIV −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- DIVU 100 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x00000064. DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- Write handling:
  - `wr_lo` with `wdata` = 0x1234 while busy → ignored; the final `lo` is the computed result.
  - A second `start` while busy → ignored.
  - `start` in the `done` cycle → new op accepted.
- Reset mid-operation: `rst_n` = 0 at CALC iteration 10 → next cycle `hi` = `lo` = 0, `busy` = 0, no `done` pulse; a fresh op afterwards produces a correct result.
- Random regression: 10k signed and unsigned ops compared against a reference model.
